// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I instruction fields into a 32-bit word behind a single valid/ready output register.
// Out-of-range immediates and unknown classes yield a zero word flagged illegal.
module instruction_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_class,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic        out_illegal,
    output logic [15:0] encoded_count,
    output logic [15:0] illegal_count
);
    logic        valid_q, valid_d, illegal_q, illegal_d;
    logic [31:0] instr_q, instr_d, word, enc_word;
    logic [15:0] enc_cnt_q, enc_cnt_d, ill_cnt_q, ill_cnt_d;
    logic        legal, fit12, fit13, fit21, is_shift, accept, drain;
    assign fit12    = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fit13    = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
    assign fit21    = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
    // only SLLI/SRLI/SRAI carry funct7 alongside a 5-bit shamt
    assign is_shift = funct3[1:0] == 2'b01;
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (op_class)
            4'd0: begin
                word  = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
                legal = 1'b1;
            end
            4'd1: begin
                word  = is_shift ? {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011}
                                 : {imm[11:0], rs1, funct3, rd, 7'b0010011};
                legal = is_shift ? (imm[31:5] == '0) : fit12;
            end
            4'd2: begin
                word  = {imm[11:0], rs1, funct3, rd, 7'b0000011};
                legal = fit12;
            end
            4'd3: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
                legal = fit12;
            end
            4'd4: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
                legal = fit13;
            end
            4'd5: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                legal = fit21;
            end
            4'd6: begin
                word  = {imm[11:0], rs1, funct3, rd, 7'b1100111};
                legal = fit12;
            end
            4'd7: begin
                word  = {imm[31:12], rd, 7'b0110111};
                legal = imm[11:0] == '0;
            end
            4'd8: begin
                word  = {imm[31:12], rd, 7'b0010111};
                legal = imm[11:0] == '0;
            end
            4'd9: begin
                word  = {imm[11:0], rs1, funct3, rd, 7'b1110011};
                legal = fit12;
            end
            default: ;
        endcase
        enc_word = legal ? word : '0;
    end
    assign in_ready  = rst && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = valid_q && out_ready;
    assign valid_d   = accept || (valid_q && !out_ready);
    assign instr_d   = accept ? enc_word : instr_q;
    assign illegal_d = accept ? !legal : illegal_q;
    assign enc_cnt_d = (drain && !illegal_q && enc_cnt_q != 16'hFFFF) ? enc_cnt_q + 16'd1 : enc_cnt_q;
    assign ill_cnt_d = (drain && illegal_q && ill_cnt_q != 16'hFFFF) ? ill_cnt_q + 16'd1 : ill_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            illegal_q <= 1'b0;
            enc_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
            enc_cnt_q <= enc_cnt_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end
    assign out_valid       = valid_q;
    assign out_instruction = instr_q;
    assign out_illegal     = illegal_q;
    assign encoded_count   = enc_cnt_q;
    assign illegal_count   = ill_cnt_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed vectors plus randomized traffic scored against an arithmetic encoding model.
module tb_instruction_encoder;
    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_illegal;
    logic [3:0]  op_class = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0, out_instruction;
    logic [15:0] encoded_count, illegal_count;
    int n_chk = 0, n_fail = 0;
    int exp_enc = 0, exp_ill = 0;
    logic [32:0] q[$];
    int unsigned bounds[13] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                                1048574, 1048576, -1048576, 31, 32};

    instruction_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_illegal(out_illegal), .encoded_count(encoded_count), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // returns {illegal, word}, derived from signed ranges and bit-position arithmetic
    function automatic logic [32:0] ref_enc(input bit [31:0] op, d, s1, s2, f3, f7, im);
        bit [31:0] w, opc, rr;
        bit ok;
        longint s;
        s  = longint'($signed(im));
        rr = (s2 << 20) | (s1 << 15) | (f3 << 12);
        ok = 1'b0;
        w  = 0;
        case (op)
            0: begin ok = 1'b1; w = (f7 << 25) | rr | (d << 7) | 'h33; end
            1, 2, 6, 9: begin
                opc = op == 1 ? 'h13 : op == 2 ? 'h03 : op == 6 ? 'h67 : 'h73;
                if (op == 1 && (f3 == 1 || f3 == 5)) begin
                    ok = im < 32;
                    w  = (f7 << 25) | (im << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
                end else begin
                    ok = s >= -2048 && s <= 2047;
                    w  = ((im & 'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
                end
            end
            3: begin
                ok = s >= -2048 && s <= 2047;
                w  = (((im >> 5) & 'h7F) << 25) | rr | ((im & 'h1F) << 7) | 'h23;
            end
            4: begin
                ok = s >= -4096 && s <= 4095 && (im % 2) == 0;
                w  = (((im >> 12) & 1) << 31) | (((im >> 5) & 'h3F) << 25) | rr |
                     (((im >> 1) & 'hF) << 8) | (((im >> 11) & 1) << 7) | 'h63;
            end
            5: begin
                ok = s >= -1048576 && s <= 1048575 && (im % 2) == 0;
                w  = (((im >> 20) & 1) << 31) | (((im >> 1) & 'h3FF) << 21) | (((im >> 11) & 1) << 20) |
                     (((im >> 12) & 'hFF) << 12) | (d << 7) | 'h6F;
            end
            7, 8: begin
                ok = (im % 4096) == 0;
                w  = (im & 'hFFFFF000) | (d << 7) | (op == 7 ? 'h37 : 'h17);
            end
            default: ok = 1'b0;
        endcase
        return {!ok, ok ? w : 32'h0};
    endfunction

    // scoreboard: one expected word may be pending, mirroring a single output slot
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            exp_enc = 0;
            exp_ill = 0;
        end else begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, q.size() == 0 || out_ready);
            chk("encoded_count", encoded_count, exp_enc);
            chk("illegal_count", illegal_count, exp_ill);
            if (q.size() != 0) begin
                chk("sb_word", out_instruction, q[0][31:0]);
                chk("sb_illegal", out_illegal, q[0][32]);
            end
            if (in_valid && (q.size() == 0 || out_ready)) begin
                if (q.size() != 0) begin
                    if (q[0][32]) exp_ill = exp_ill < 65535 ? exp_ill + 1 : exp_ill;
                    else exp_enc = exp_enc < 65535 ? exp_enc + 1 : exp_enc;
                    void'(q.pop_front());
                end
                q.push_back(ref_enc(op_class, rd, rs1, rs2, funct3, funct7, imm));
            end else if (q.size() != 0 && out_ready) begin
                if (q[0][32]) exp_ill = exp_ill < 65535 ? exp_ill + 1 : exp_ill;
                else exp_enc = exp_enc < 65535 ? exp_enc + 1 : exp_enc;
                void'(q.pop_front());
            end
        end
    end

    task automatic set_fields(input [3:0] op, input [4:0] d, s1, s2, input [2:0] f3, input [6:0] f7, input [31:0] im);
        op_class = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic send(input [3:0] op, input [4:0] d, s1, s2, input [2:0] f3, input [6:0] f7,
                        input [31:0] im, input [31:0] ew, input bit ei, input string tag);
        int t = 0;
        @(posedge clk); #1;
        set_fields(op, d, s1, s2, f3, f7, im);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        chk({tag, "_accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk(tag, out_instruction, ew);
        chk({tag, "_ill"}, out_illegal, ei);
    endtask

    task automatic rand_fields();
        int unsigned k;
        k = $urandom_range(0, 5);
        op_class = $urandom_range(0, 15);
        rd = $urandom; rs1 = $urandom; rs2 = $urandom;
        funct3 = $urandom; funct7 = $urandom;
        imm = k == 0 ? $urandom :
              k == 1 ? $urandom_range(0, 8191) - 4096 :
              k == 2 ? bounds[$urandom_range(0, 12)] :
              k == 3 ? ($urandom & 32'hFFFFF000) :
              k == 4 ? $urandom_range(0, 40) :
                       $urandom_range(0, 4194303) - 2097152;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_word", out_instruction, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_enc_cnt", encoded_count, 0);
        chk("rst_ill_cnt", illegal_count, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        send(1, 15, 0, 0, 0, 0, 23, 32'h01700793, 0, "addi");
        @(negedge clk);
        chk("enc_cnt_1", encoded_count, 1);
        send(0, 3, 1, 2, 0, 0, 0, 32'h002081B3, 0, "add");
        send(3, 0, 2, 5, 2, 0, 8, 32'h00512423, 0, "sw");
        send(4, 0, 0, 0, 0, 0, -4, 32'hFE000EE3, 0, "beq");
        send(7, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7, 0, "lui");
        send(1, 1, 1, 0, 5, 7'h20, 3, 32'h4030D093, 0, "srai");
        send(1, 1, 1, 0, 0, 0, 2048, 0, 1, "ill_imm");
        send(4, 0, 1, 2, 0, 0, 3, 0, 1, "ill_br");
        send(12, 1, 1, 1, 0, 0, 0, 0, 1, "ill_cls");
        @(negedge clk);
        chk("ill_cnt_3", illegal_count, 3);

        @(posedge clk); #1;
        set_fields(1, 1, 0, 0, 0, 0, 5);
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            @(negedge clk);
            chk("bp_word", out_instruction, 32'h00500093);
            chk("bp_ready", in_ready, 0);
            chk("bp_enc_cnt", encoded_count, 6);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_valid", out_valid, 1);
            chk("b2b_ready", in_ready, 1);
            @(posedge clk); #1;
            rand_fields();
        end
        #3;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_word", out_instruction, 0);
        chk("arst_enc_cnt", encoded_count, 0);
        chk("arst_ill_cnt", illegal_count, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_arst", in_ready, 1);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            rand_fields();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Streaming RV32I instruction encoder, the inverse of the instruction decoder. It accepts one instruction per transaction as an instruction class, register indices, funct fields and a 32-bit immediate, and emits the packed 32-bit machine word through a registered valid/ready output stage. Immediates outside the format's range are flagged as illegal. It sits between test/program generators (or a microcode sequencer) and instruction memory or the fetch path.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- op_class  in  4  0 reg-arith (R), 1 imm-arith (I), 2 load (I), 3 store (S), 4 branch (B), 5 JAL (J), 6 JALR (I), 7 LUI (U), 8 AUIPC (U), 9 SYSTEM (I); 10-15 illegal.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3;  funct7  in  7.
- imm  in  32  full signed byte offset or value.
- out_valid  out  1;  out_ready  in  1.
- out_instruction  out  32  encoded word.
- out_illegal  out  1  word rejected; out_instruction = 0.
- encoded_count  out  16  legal words delivered, saturating.
- illegal_count  out  16  illegal words delivered, saturating.

## Operation
- Opcodes: R 0110011, imm-arith 0010011, load 0000011, store 0100011, branch 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
- Packing: standard RV32I fields. rd in [11:7], funct3 in [14:12], rs1 in [19:15], rs2 in [24:20], funct7 in [31:25]. Fields the format lacks are ignored.
- I: imm[11:0] goes to [31:20]. Legal iff imm[31:11] is all-equal (12-bit signed range).
- Shift immediates (imm-arith with funct3 001 or 101): funct7 goes to [31:25] and imm[4:0] to [24:20]. Legal iff imm[31:5] == 0.
- S: imm[11:5] goes to [31:25] and imm[4:0] to [11:7]. Same range rule as I.
- B: imm[12|10:5] goes to [31:25] and imm[4:1|11] to [11:7]. Legal iff imm[31:12] is all-equal and imm[0] == 0.
- J: imm[20|10:1|11|19:12] goes to [31:12]. Legal iff imm[31:20] is all-equal and imm[0] == 0.
- U: imm[31:12] goes to [31:12]. Legal iff imm[11:0] == 0.
- Illegal op_class or failed range check: out_illegal = 1 and out_instruction = 32'h0000_0000.
- Output register: a single stage. in_ready = !out_valid || out_ready, forced to 0 while rst is low.
- On an accepted request, the encoded word, the illegal flag and out_valid = 1 load together. Without a new accept, a completed handshake clears out_valid.
- Counters: increment when out_valid && out_ready, selected by out_illegal. Each counter holds at 16'hFFFF.

## Timing
- Reset (async, rst low): out_valid = 0, out_instruction = 0, out_illegal = 0, both counters = 0, in_ready = 0.
- in_ready is 1 in the first cycle after rst rises.
- Latency: the request is accepted at edge N and out_valid is high after edge N.
- Throughput: one word per cycle while out_ready is held high. Accept and drain in the same cycle are allowed.
- Backpressure: while out_valid && !out_ready, out_instruction and out_illegal hold stable and in_ready = 0.
- Reset asserted mid-transfer: the pending output is discarded immediately, asynchronously, and counters clear.
- Inputs are sampled only on the accept edge. Changes while in_ready = 0 have no effect.

## Test plan
- op_class 1, rd 15, rs1 0, funct3 0, imm 23 -> out_instruction 0x01700793, out_illegal 0, encoded_count 1.
- R: rd 3, rs1 1, rs2 2, funct3 0, funct7 0 -> 0x002081B3.
- S, then B: S with rs1 2, rs2 5, funct3 2, imm 8 -> 0x00512423. B with rs1 0, rs2 0, funct3 0, imm -4 -> 0xFE000EE3.
- U, then shift: LUI rd 5, imm 0x12345000 -> 0x123452B7. SRAI with rd 1, rs1 1, funct3 5, funct7 0x20, imm 3 -> 0x4030D093.
- Illegal, three cases. Each gives out_illegal 1 and word 0; illegal_count reaches 3.
  - imm-arith with imm 2048.
  - Branch with imm 3.
  - op_class 12.
- Backpressure and reset:
  - Hold out_ready 0 for 5 cycles with in_valid high: word stable, in_ready 0, no counter change.
  - Release out_ready: back-to-back words delivered, one per cycle.
  - Pull rst low mid-stream: out_valid drops without waiting for a clock edge.
